// File: rtl/alu_mb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_mb_pkg
//  Description : Shared types for the multi-bank ALU: command and response
//                encodings plus the per-channel FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_mb_pkg;

    // 3-bit command encoding; 3'd7 is deliberately left undefined and
    // produces an INVALID response.
    typedef enum logic [2:0] {
        NOP      = 3'd0,
        ADD      = 3'd1,
        MULTIPLY = 3'd2,
        AND      = 3'd3,
        SUB      = 3'd4,
        OR       = 3'd5,
        XOR      = 3'd6
    } command_names_t;

    typedef enum logic [1:0] {
        NO_RESPONSE = 2'd0,
        SUCCESS     = 2'd1,
        OVERFLOW    = 2'd2,
        INVALID     = 2'd3
    } response_names_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } chan_state_t;

endpackage : alu_mb_pkg
`default_nettype wire

// File: rtl/alu_channel.sv
`default_nettype none
// ============================================================================
//  Module      : alu_channel
//  Description : One independent ALU bank. Accepts a command when not busy,
//                waits a command-dependent latency, then emits a one-cycle
//                response and holds the result until the next response.
//                Commands arriving while busy are counted (saturating).
//  Ports       : clk_i, rst_ni        clock / async active-low reset
//                cmd_i, data1_i/2_i   command and operands
//                resp_o, data_o       one-cycle response, held result
//                busy_o               executing, new commands are dropped
//                drop_count_o         saturating dropped-command count
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_channel
    import alu_mb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BASE_LAT   = 3,
    parameter int MUL_LAT    = 5,
    parameter int DROP_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  command_names_t        cmd_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    output response_names_t       resp_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic [DROP_W-1:0]     drop_count_o
);

    localparam int                CNT_W  = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0]  C_BASE = CNT_W'(BASE_LAT);
    localparam logic [CNT_W-1:0]  C_MUL  = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    chan_state_t             state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    command_names_t          cmd_q,    cmd_d;
    logic [DATA_WIDTH-1:0]   op1_q,    op1_d;
    logic [DATA_WIDTH-1:0]   op2_q,    op2_d;
    response_names_t         resp_q,   resp_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic [DROP_W-1:0]       drop_q,   drop_d;

    logic                    req_w;
    logic                    accept_w;
    logic [CNT_W-1:0]        lat_w;
    logic [DATA_WIDTH:0]     sum_w;
    logic [2*DATA_WIDTH-1:0] prod_w;
    logic [DATA_WIDTH-1:0]   res_data_w;
    response_names_t         res_resp_w;

    assign req_w    = (cmd_i != NOP);
    // The final RESP cycle is not busy, so a command there is taken
    // back-to-back rather than dropped.
    assign accept_w = req_w && (state_q != ST_EXEC);
    assign lat_w    = (cmd_i == MULTIPLY) ? C_MUL : C_BASE;

    assign sum_w  = {1'b0, op1_q} + {1'b0, op2_q};
    assign prod_w = {{DATA_WIDTH{1'b0}}, op1_q} * {{DATA_WIDTH{1'b0}}, op2_q};

    // Datapath on the operands captured at accept time.
    always_comb begin
        res_data_w = '0;
        res_resp_w = SUCCESS;
        case (cmd_q)
            ADD: begin
                res_data_w = sum_w[DATA_WIDTH-1:0];
                res_resp_w = sum_w[DATA_WIDTH] ? OVERFLOW : SUCCESS;
            end
            SUB: begin
                res_data_w = op1_q - op2_q;
                res_resp_w = (op2_q > op1_q) ? OVERFLOW : SUCCESS;
            end
            MULTIPLY: begin
                res_data_w = prod_w[DATA_WIDTH-1:0];
                res_resp_w = (|prod_w[2*DATA_WIDTH-1:DATA_WIDTH]) ? OVERFLOW : SUCCESS;
            end
            AND: res_data_w = op1_q & op2_q;
            OR:  res_data_w = op1_q | op2_q;
            XOR: res_data_w = op1_q ^ op2_q;
            default: begin
                res_data_w = '0;
                res_resp_w = INVALID;
            end
        endcase
    end

    // Next-state logic. RESP is the last cycle of an operation: the result
    // is registered on the edge leaving RESP, so the response appears
    // exactly LAT edges after the accepting edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = NO_RESPONSE;
        data_d  = data_q;
        drop_d  = drop_q;

        case (state_q)
            ST_EXEC: begin
                cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = ST_RESP;
                end
                if (req_w && (drop_q != '1)) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
            ST_RESP: begin
                resp_d  = res_resp_w;
                data_d  = res_data_w;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_w) begin
            cmd_d = cmd_i;
            op1_d = data1_i;
            op2_d = data2_i;
            if (lat_w == C_ONE) begin
                state_d = ST_RESP;
                cnt_d   = '0;
            end else begin
                state_d = ST_EXEC;
                cnt_d   = lat_w - C_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= NOP;
            op1_q   <= '0;
            op2_q   <= '0;
            resp_q  <= NO_RESPONSE;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign resp_o       = resp_q;
    assign data_o       = data_q;
    assign busy_o       = (state_q == ST_EXEC);
    assign drop_count_o = drop_q;

endmodule : alu_channel
`default_nettype wire

// File: rtl/alu_multibank.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multibank
//  Description : NUM_BANKS fully independent ALU channels sharing only the
//                clock and reset.
//  Ports       : clock, reset (async, active low)
//                in_command/in_data1/in_data2   per-bank request
//                out_response/out_data          per-bank response / result
//                busy, drop_count               per-bank status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_multibank
    import alu_mb_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_LAT   = 3,
    parameter int MUL_LAT    = 5,
    parameter int DROP_W     = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  command_names_t  [NUM_BANKS-1:0]       in_command,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  in_data1,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  in_data2,
    output response_names_t [NUM_BANKS-1:0]       out_response,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [NUM_BANKS-1:0]                  busy,
    output logic [NUM_BANKS-1:0][DROP_W-1:0]      drop_count
);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        alu_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .BASE_LAT   (BASE_LAT),
            .MUL_LAT    (MUL_LAT),
            .DROP_W     (DROP_W)
        ) u_channel (
            .clk_i        (clock),
            .rst_ni       (reset),
            .cmd_i        (in_command[g]),
            .data1_i      (in_data1[g]),
            .data2_i      (in_data2[g]),
            .resp_o       (out_response[g]),
            .data_o       (out_data[g]),
            .busy_o       (busy[g]),
            .drop_count_o (drop_count[g])
        );
    end

endmodule : alu_multibank
`default_nettype wire

// File: tb/tb_alu_multibank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multibank
//  Description : Scoreboard bench for alu_multibank. Stimulus pushes the
//                expected response (value and arrival cycle) per bank; a
//                monitor on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multibank;
    import alu_mb_pkg::*;

    localparam int NB   = 4;
    localparam int DW   = 32;
    localparam int BLAT = 3;
    localparam int MLAT = 5;
    localparam int DRW  = 8;

    typedef struct {
        int                cyc;
        response_names_t   resp;
        logic [DW-1:0]     data;
    } exp_t;

    logic                           clock;
    logic                           reset;
    command_names_t [NB-1:0]        in_command;
    logic [NB-1:0][DW-1:0]          in_data1;
    logic [NB-1:0][DW-1:0]          in_data2;
    response_names_t [NB-1:0]       out_response;
    logic [NB-1:0][DW-1:0]          out_data;
    logic [NB-1:0]                  busy;
    logic [NB-1:0][DRW-1:0]         drop_count;

    alu_multibank #(
        .NUM_BANKS  (NB),
        .DATA_WIDTH (DW),
        .BASE_LAT   (BLAT),
        .MUL_LAT    (MLAT),
        .DROP_W     (DRW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_command   (in_command),
        .in_data1     (in_data1),
        .in_data2     (in_data2),
        .out_response (out_response),
        .out_data     (out_data),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard / reference state
    exp_t          q[NB][$];
    int            ready_e[NB];
    int            last_acc[NB];
    int            drop_m[NB];
    logic [DW-1:0] last_data[NB];

    int total = 0;
    int bad   = 0;

    // Per-step stimulus slots (cleared to NOP after every step)
    logic [2:0]    cmd_v[NB];
    logic [DW-1:0] d1_v[NB];
    logic [DW-1:0] d2_v[NB];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: plain wide unsigned math.
    function automatic void model_op(input logic [2:0] c, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b,
                                     output response_names_t r, output logic [DW-1:0] d);
        logic [2*DW-1:0] wide;
        r = SUCCESS;
        d = '0;
        case (c)
            3'd1: begin wide = (2*DW)'(a) + (2*DW)'(b); d = wide[DW-1:0];
                        r = (wide > (2*DW)'({DW{1'b1}})) ? OVERFLOW : SUCCESS; end
            3'd2: begin wide = (2*DW)'(a) * (2*DW)'(b); d = wide[DW-1:0];
                        r = ((wide >> DW) != 0) ? OVERFLOW : SUCCESS; end
            3'd3: d = a & b;
            3'd4: begin d = a - b; r = (b > a) ? OVERFLOW : SUCCESS; end
            3'd5: d = a | b;
            3'd6: d = a ^ b;
            default: begin d = '0; r = INVALID; end
        endcase
    endfunction

    // Drive one cycle of commands; the model decides accept/drop for the
    // edge that will sample them.
    task automatic step();
        int e;
        int lat;
        response_names_t r;
        logic [DW-1:0] d;
        e = cyc + 1;
        for (int b = 0; b < NB; b++) begin
            in_command[b] = command_names_t'(cmd_v[b]);
            in_data1[b]   = d1_v[b];
            in_data2[b]   = d2_v[b];
            if (cmd_v[b] != 3'd0) begin
                if (e >= ready_e[b]) begin
                    lat = (cmd_v[b] == 3'd2) ? MLAT : BLAT;
                    model_op(cmd_v[b], d1_v[b], d2_v[b], r, d);
                    q[b].push_back('{e + lat, r, d});
                    last_acc[b] = e;
                    ready_e[b]  = e + lat;
                end else if (drop_m[b] < 255) begin
                    drop_m[b]++;
                end
            end
        end
        @(posedge clock);
        #1;
        for (int b = 0; b < NB; b++) begin
            cmd_v[b] = 3'd0;
            d1_v[b]  = $urandom;
            d2_v[b]  = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int b, input logic [2:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] bb);
        cmd_v[b] = c;
        d1_v[b]  = a;
        d2_v[b]  = bb;
    endtask

    task automatic clear_model();
        for (int b = 0; b < NB; b++) begin
            q[b].delete();
            ready_e[b]   = 0;
            last_acc[b]  = 0;
            drop_m[b]    = 0;
            last_data[b] = '0;
            cmd_v[b]     = 3'd0;
            in_command[b] = NOP;
        end
    endtask

    function automatic logic [DW-1:0] pick();
        logic [DW-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'h0000_FFFF;
            3: v = 32'h0001_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every falling edge, each bank either shows the expected
    // response at the expected cycle or holds its last result.
    always @(negedge clock) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                exp_t ex;
                logic bexp;
                total++;
                if (out_response[b] != NO_RESPONSE) begin
                    if (q[b].size() == 0) begin
                        bad++;
                        $display("FAIL bank%0d unexpected response: got %0d/%0h expected none (cycle %0d)",
                                 b, out_response[b], out_data[b], cyc);
                    end else begin
                        ex = q[b].pop_front();
                        last_data[b] = ex.data;
                        if (out_response[b] !== ex.resp || out_data[b] !== ex.data || cyc != ex.cyc) begin
                            bad++;
                            $display("FAIL bank%0d response: got %0d/%0h at cycle %0d expected %0d/%0h at cycle %0d",
                                     b, out_response[b], out_data[b], cyc, ex.resp, ex.data, ex.cyc);
                        end
                    end
                end else if (q[b].size() != 0 && q[b][0].cyc <= cyc) begin
                    ex = q[b].pop_front();
                    last_data[b] = ex.data;
                    bad++;
                    $display("FAIL bank%0d missing response: got none expected %0d/%0h at cycle %0d",
                             b, ex.resp, ex.data, ex.cyc);
                end else if (out_data[b] !== last_data[b]) begin
                    bad++;
                    $display("FAIL bank%0d held data: got %0h expected %0h (cycle %0d)",
                             b, out_data[b], last_data[b], cyc);
                end
                bexp = (cyc >= last_acc[b]) && (cyc < ready_e[b] - 1);
                total++;
                if (busy[b] !== bexp) begin
                    bad++;
                    $display("FAIL bank%0d busy: got %0b expected %0b (cycle %0d)", b, busy[b], bexp, cyc);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s resp%0d", tag, b), 64'(out_response[b]), 64'(NO_RESPONSE));
            chk($sformatf("%s data%0d", tag, b), 64'(out_data[b]), 64'd0);
            chk($sformatf("%s busy%0d", tag, b), 64'(busy[b]), 64'd0);
            chk($sformatf("%s drop%0d", tag, b), 64'(drop_count[b]), 64'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_model();
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic check_drops(input string tag);
        for (int b = 0; b < NB; b++)
            chk($sformatf("%s drop%0d", tag, b), 64'(drop_count[b]), 64'(drop_m[b]));
    endtask

    initial begin
        reset = 1'b0;
        for (int b = 0; b < NB; b++) begin
            in_command[b] = NOP;
            in_data1[b]   = '0;
            in_data2[b]   = '0;
            cmd_v[b]      = 3'd0;
            d1_v[b]       = '0;
            d2_v[b]       = '0;
        end
        #2;
        do_reset();

        // 1: reset in the middle of a MULTIPLY on bank 2
        issue(2, 3'd1, 32'd1, 32'd2);
        step();
        idle(5);
        issue(2, 3'd2, 32'h1234, 32'h5678);
        step();
        idle(2);
        do_reset();
        idle(10);

        // 2: ADD carry-out on bank 0
        issue(0, 3'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        idle(5);

        // 3: MULTIPLY overflow and full-width success on bank 1
        issue(1, 3'd2, 32'h0001_0000, 32'h0001_0000);
        step();
        idle(6);
        issue(1, 3'd2, 32'h0000_FFFF, 32'h0001_0001);
        step();
        idle(6);

        // 4: SUB borrow and XOR on bank 3
        issue(3, 3'd4, 32'd5, 32'd7);
        step();
        idle(4);
        issue(3, 3'd6, 32'hF0F0_F0F0, 32'hFFFF_0000);
        step();
        idle(4);

        // 5: ADD every cycle while busy on bank 0, then saturate the counter
        for (int i = 0; i < 4; i++) begin
            issue(0, 3'd1, 32'(i + 1), 32'(i * 3));
            step();
        end
        idle(5);
        chk("drop2 bank0", 64'(drop_count[0]), 64'd2);
        check_drops("after back-to-back");
        for (int i = 0; i < 460; i++) begin
            issue(0, 3'd1, $urandom, $urandom);
            step();
        end
        idle(6);
        chk("drop saturate bank0", 64'(drop_count[0]), 64'hFF);

        // 6: undefined encoding, then random traffic on all banks
        do_reset();
        issue(2, 3'd7, 32'hDEAD_BEEF, 32'h1);
        step();
        idle(5);
        begin
            int gap[NB];
            for (int b = 0; b < NB; b++) gap[b] = 0;
            for (int i = 0; i < 4000; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (gap[b] == 0) begin
                        issue(b, 3'($urandom_range(1, 7)), pick(), pick());
                        gap[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                             : $urandom_range(0, 3);
                    end else begin
                        gap[b]--;
                    end
                end
                step();
            end
        end
        idle(8);
        check_drops("random");
        for (int b = 0; b < NB; b++)
            chk($sformatf("drain bank%0d", b), 64'(q[b].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_multibank
`default_nettype wire
